// File: rtl/axi_dma_master_if.sv
// AXI4 master bus bundle for the memory-to-memory copy engine.
// Groups the five AXI channels (AR, R, AW, W, B).
//   master modport : used by axi_dma_master
//   slave  modport : used by whatever provides the two target memories
interface axi_dma_master_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    // AR channel
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    // R channel
    logic                    rvalid;
    logic                    rready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rlast;
    logic [1:0]              rresp;
    // AW channel
    logic                    awvalid;
    logic                    awready;
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    // W channel
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    // B channel
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rlast, rresp,
        output rready,
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rlast, rresp,
        input  rready,
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready
    );
endinterface

// File: rtl/axi_dma_master.sv
// AXI4 memory-to-memory copy engine.
// A start pulse while idle copies r_len bytes (whole words only) from r_src_addr
// to r_dst_addr. Reads land in a small FIFO; writes drain it. Read bursts only
// issue once FIFO space for all their beats is reserved, so RREADY can stay high.
// Ports:
//   ACLK, ARESETn           clock, asynchronous active-low reset
//   w_start                 one-cycle start pulse (ignored while busy)
//   r_src_addr, r_dst_addr  byte addresses (sub-word bits dropped)
//   r_len                   length in bytes (sub-word remainder dropped)
//   m_axi                   AXI4 master bundle (AR/R/AW/W/B)
//
// state  | meaning
// S_IDLE | waiting for w_start; RREADY/BREADY low, no VALIDs
// S_BUSY | copy running; done when every burst has its B response
module axi_dma_master #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LGMAXBURST = 2,
    parameter int LGFIFO     = LGMAXBURST + 1,
    parameter int LGLEN      = ADDR_WIDTH
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  w_start,
    input  logic [ADDR_WIDTH-1:0] r_src_addr,
    input  logic [ADDR_WIDTH-1:0] r_dst_addr,
    input  logic [LGLEN-1:0]      r_len,
    axi_dma_master_if.master      m_axi
);
    localparam int ADDRLSB = $clog2(DATA_WIDTH/8);
    localparam int MAXB    = 1 << LGMAXBURST;
    localparam int DEPTH   = 1 << LGFIFO;
    localparam int BW      = LGMAXBURST + 1;
    localparam int FW      = LGFIFO + 1;
    localparam int CW      = LGLEN;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << ADDRLSB) - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;
    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] rd_addr, aw_addr, w_addr;
    logic [CW-1:0]         rd_left, aw_left, w_left;
    logic [CW-1:0]         aw_avail;     // beats received but not yet claimed by an AW
    logic [CW-1:0]         b_cnt;        // AWs still waiting for their B
    logic [FW-1:0]         space;        // FIFO slots not reserved by an AR
    logic [FW-1:0]         fill;
    logic [LGFIFO-1:0]     wr_ptr, rd_ptr;
    logic [BW-1:0]         w_cnt;        // beats left in current W burst, 0 = burst not started
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Bursts stop at MAXB-beat aligned boundaries. That boundary is a power of
    // two no larger than 4KB, so no burst can cross a 4KB page either.
    function automatic logic [BW-1:0] burst_beats(input logic [ADDR_WIDTH-1:0] addr,
                                                  input logic [CW-1:0] left);
        logic [BW-1:0] to_bound;
        to_bound = BW'(MAXB) - BW'(addr[ADDRLSB +: LGMAXBURST]);
        if (left < CW'(to_bound))
            burst_beats = BW'(left);
        else
            burst_beats = to_bound;
    endfunction

    logic          busy, start_ok, push, pop, ar_hs, aw_hs, b_hs;
    logic [CW-1:0] n_words;
    logic [BW-1:0] ar_beats, aw_beats, w_len_cur;

    assign busy      = (state == S_BUSY);
    assign n_words   = r_len >> ADDRLSB;
    assign start_ok  = !busy && w_start && (n_words != '0);
    assign ar_beats  = burst_beats(rd_addr, rd_left);
    assign aw_beats  = burst_beats(aw_addr, aw_left);
    assign w_len_cur = (w_cnt == '0) ? burst_beats(w_addr, w_left) : w_cnt;

    // VALIDs come from registers only; each condition can only stay true until
    // its handshake, so valid and payload hold while the slave stalls.
    assign m_axi.arvalid = busy && (rd_left != '0) && (space >= FW'(ar_beats));
    assign m_axi.arid    = '0;
    assign m_axi.araddr  = rd_addr;
    assign m_axi.arlen   = 8'(ar_beats) - 8'd1;
    assign m_axi.arsize  = 3'(ADDRLSB);
    assign m_axi.arburst = 2'b01;
    assign m_axi.rready  = busy;

    assign m_axi.awvalid = busy && (aw_left != '0) && (aw_avail >= CW'(aw_beats));
    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = aw_addr;
    assign m_axi.awlen   = 8'(aw_beats) - 8'd1;
    assign m_axi.awsize  = 3'(ADDRLSB);
    assign m_axi.awburst = 2'b01;

    assign m_axi.wvalid  = busy && (w_left != '0) && (fill != '0);
    assign m_axi.wdata   = mem[rd_ptr];
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = (w_len_cur == BW'(1));
    assign m_axi.bready  = busy;

    assign ar_hs = m_axi.arvalid && m_axi.arready;
    assign aw_hs = m_axi.awvalid && m_axi.awready;
    assign push  = m_axi.rvalid && busy;
    assign pop   = m_axi.wvalid && m_axi.wready;
    assign b_hs  = m_axi.bvalid && busy && (b_cnt != '0);

    logic unused_inputs;
    assign unused_inputs = ^{m_axi.rid, m_axi.rlast, m_axi.rresp, m_axi.bid, m_axi.bresp};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start_ok) state_nx = S_BUSY;
            S_BUSY: if ((rd_left == '0) && (aw_left == '0) && (w_left == '0) && (b_cnt == '0))
                        state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_addr  <= '0;
            aw_addr  <= '0;
            w_addr   <= '0;
            rd_left  <= '0;
            aw_left  <= '0;
            w_left   <= '0;
            aw_avail <= '0;
            b_cnt    <= '0;
            space    <= '0;
            fill     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            w_cnt    <= '0;
        end else if (start_ok) begin
            rd_addr  <= r_src_addr & ALIGN_MASK;
            aw_addr  <= r_dst_addr & ALIGN_MASK;
            w_addr   <= r_dst_addr & ALIGN_MASK;
            rd_left  <= n_words;
            aw_left  <= n_words;
            w_left   <= n_words;
            aw_avail <= '0;
            b_cnt    <= '0;
            space    <= FW'(DEPTH);
            fill     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            w_cnt    <= '0;
        end else begin
            if (ar_hs) begin
                rd_addr <= rd_addr + (ADDR_WIDTH'(ar_beats) << ADDRLSB);
                rd_left <= rd_left - CW'(ar_beats);
            end
            if (aw_hs) begin
                aw_addr <= aw_addr + (ADDR_WIDTH'(aw_beats) << ADDRLSB);
                aw_left <= aw_left - CW'(aw_beats);
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                w_addr <= w_addr + ADDR_WIDTH'(DATA_WIDTH/8);
                w_left <= w_left - 1'b1;
                w_cnt  <= w_len_cur - BW'(1);
            end
            space    <= space - (ar_hs ? FW'(ar_beats) : FW'(0)) + FW'(pop);
            fill     <= fill + FW'(push) - FW'(pop);
            aw_avail <= aw_avail + CW'(push) - (aw_hs ? CW'(aw_beats) : CW'(0));
            b_cnt    <= b_cnt + CW'(aw_hs) - CW'(b_hs);
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= m_axi.rdata;
    end
endmodule

// File: tb/tb_axi_dma_master.sv
// Bench for axi_dma_master: read/write memory slave models plus a scoreboard of
// expected AR, AW and W beats built from the requested copy before each start.
module tb_axi_dma_master;
    localparam int AWD = 10;
    localparam int DW  = 32;

    logic           ACLK = 1'b0;
    logic           ARESETn = 1'b0;
    logic           w_start = 1'b0;
    logic [AWD-1:0] r_src_addr = '0;
    logic [AWD-1:0] r_dst_addr = '0;
    logic [AWD-1:0] r_len = '0;

    always #5 ACLK = ~ACLK;

    axi_dma_master_if #(.ID_WIDTH(1), .ADDR_WIDTH(AWD), .DATA_WIDTH(DW)) bus ();

    axi_dma_master #(.ID_WIDTH(1), .ADDR_WIDTH(AWD), .DATA_WIDTH(DW),
                     .LGMAXBURST(2), .LGFIFO(3), .LGLEN(AWD)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .w_start(w_start),
        .r_src_addr(r_src_addr), .r_dst_addr(r_dst_addr), .r_len(r_len),
        .m_axi(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit stall    = 1'b0;
    int valid_seen = 0;

    logic [31:0] src_mem [256];
    logic [31:0] dst_mem [256];

    logic [9:0]  exp_ar_addr[$], exp_aw_addr[$], ar_addr_q[$], aw_addr_q[$];
    int          exp_ar_len[$], exp_aw_len[$], ar_len_q[$], aw_len_q[$];
    logic [31:0] exp_wd[$], wd_q[$];
    bit          exp_wl[$];

    logic [9:0]  rb_addr;
    int          rb_left = 0;
    int          b_pend = 0;
    bit          r_taken = 0, b_taken = 0;
    bit          ar_hold = 0, aw_hold = 0, w_hold = 0;
    logic [63:0] ar_hold_v, aw_hold_v, w_hold_v;
    logic [9:0]  wa;
    int          wl;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic flush_slave();
        ar_addr_q.delete(); ar_len_q.delete();
        aw_addr_q.delete(); aw_len_q.delete();
        wd_q.delete();
        rb_left = 0; b_pend = 0; r_taken = 0; b_taken = 0;
        ar_hold = 0; aw_hold = 0; w_hold = 0;
    endtask

    // Slave models: observe at negedge, drive 1 time unit after posedge.
    initial begin
        bus.arready = 0; bus.rvalid = 0; bus.rid = '0; bus.rdata = '0; bus.rlast = 0; bus.rresp = '0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bid = '0; bus.bresp = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                flush_slave();
            end else begin
                if (bus.arvalid || bus.awvalid) valid_seen++;

                if (ar_hold) chk("ar_stable", 64'({bus.arvalid, bus.araddr, bus.arlen}), ar_hold_v);
                ar_hold   = bus.arvalid && !bus.arready;
                ar_hold_v = 64'({bus.arvalid, bus.araddr, bus.arlen});
                if (bus.arvalid && bus.arready) begin
                    chk("ar_expected", 64'(exp_ar_addr.size() != 0), 64'd1);
                    if (exp_ar_addr.size() != 0) begin
                        chk("ar_addr", 64'(bus.araddr), 64'(exp_ar_addr.pop_front()));
                        chk("ar_len", 64'(bus.arlen), 64'(exp_ar_len.pop_front()));
                        chk("ar_id_size_burst", 64'({bus.arid, bus.arsize, bus.arburst}), 64'({1'b0, 3'd2, 2'b01}));
                    end
                    ar_addr_q.push_back(bus.araddr);
                    ar_len_q.push_back(int'(bus.arlen));
                end
                r_taken = bus.rvalid && bus.rready;
                if (r_taken) begin
                    rb_addr = rb_addr + 10'd4;
                    rb_left--;
                end

                if (aw_hold) chk("aw_stable", 64'({bus.awvalid, bus.awaddr, bus.awlen}), aw_hold_v);
                aw_hold   = bus.awvalid && !bus.awready;
                aw_hold_v = 64'({bus.awvalid, bus.awaddr, bus.awlen});
                if (bus.awvalid && bus.awready) begin
                    chk("aw_expected", 64'(exp_aw_addr.size() != 0), 64'd1);
                    if (exp_aw_addr.size() != 0) begin
                        chk("aw_addr", 64'(bus.awaddr), 64'(exp_aw_addr.pop_front()));
                        chk("aw_len", 64'(bus.awlen), 64'(exp_aw_len.pop_front()));
                        chk("aw_id_size_burst", 64'({bus.awid, bus.awsize, bus.awburst}), 64'({1'b0, 3'd2, 2'b01}));
                    end
                    aw_addr_q.push_back(bus.awaddr);
                    aw_len_q.push_back(int'(bus.awlen));
                end

                if (w_hold) chk("w_stable", 64'({bus.wvalid, bus.wdata, bus.wlast}), w_hold_v);
                w_hold   = bus.wvalid && !bus.wready;
                w_hold_v = 64'({bus.wvalid, bus.wdata, bus.wlast});
                if (bus.wvalid && bus.wready) begin
                    chk("w_expected", 64'(exp_wd.size() != 0), 64'd1);
                    if (exp_wd.size() != 0) begin
                        chk("w_data", 64'(bus.wdata), 64'(exp_wd.pop_front()));
                        chk("w_last", 64'(bus.wlast), 64'(exp_wl.pop_front()));
                        chk("w_strb", 64'(bus.wstrb), 64'h0f);
                    end
                    wd_q.push_back(bus.wdata);
                end

                b_taken = bus.bvalid && bus.bready;

                while (aw_addr_q.size() > 0 && wd_q.size() >= aw_len_q[0] + 1) begin
                    wa = aw_addr_q.pop_front();
                    wl = aw_len_q.pop_front();
                    for (int k = 0; k <= wl; k++) dst_mem[int'(wa[9:2]) + k] = wd_q.pop_front();
                    b_pend++;
                end
            end

            @(posedge ACLK);
            #1;
            if (!ARESETn) begin
                bus.arready = 0; bus.awready = 0; bus.wready = 0;
                bus.rvalid = 0; bus.rlast = 0; bus.bvalid = 0;
            end else begin
                bus.arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.awready = 1'b1;
                bus.wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!(bus.rvalid && !r_taken)) begin
                    if (rb_left == 0 && ar_addr_q.size() > 0) begin
                        rb_addr = ar_addr_q.pop_front();
                        rb_left = ar_len_q.pop_front() + 1;
                    end
                    if (rb_left > 0 && (!stall || $urandom_range(0, 1) == 1)) begin
                        bus.rvalid = 1'b1;
                        bus.rdata  = src_mem[rb_addr[9:2]];
                        bus.rlast  = (rb_left == 1);
                    end else begin
                        bus.rvalid = 1'b0;
                        bus.rlast  = 1'b0;
                    end
                end
                if (!(bus.bvalid && !b_taken)) begin
                    if (b_pend > 0) begin
                        bus.bvalid = 1'b1;
                        b_pend--;
                    end else begin
                        bus.bvalid = 1'b0;
                    end
                end
            end
        end
    end

    task automatic clear_exp();
        exp_ar_addr.delete(); exp_ar_len.delete();
        exp_aw_addr.delete(); exp_aw_len.delete();
        exp_wd.delete(); exp_wl.delete();
    endtask

    task automatic build_exp(input logic [9:0] src, input logic [9:0] dst, input int len);
        logic [9:0] a;
        int left, b, si;
        a = src & 10'h3fc;
        left = len >> 2;
        while (left > 0) begin
            b = 4 - int'(a[3:2]);
            if (left < b) b = left;
            exp_ar_addr.push_back(a);
            exp_ar_len.push_back(b - 1);
            a = a + 10'(b * 4);
            left -= b;
        end
        a = dst & 10'h3fc;
        left = len >> 2;
        si = int'(src[9:2]);
        while (left > 0) begin
            b = 4 - int'(a[3:2]);
            if (left < b) b = left;
            exp_aw_addr.push_back(a);
            exp_aw_len.push_back(b - 1);
            for (int k = 0; k < b; k++) begin
                exp_wd.push_back(src_mem[si]);
                exp_wl.push_back(k == b - 1);
                si++;
            end
            a = a + 10'(b * 4);
            left -= b;
        end
    endtask

    task automatic run_copy(input logic [9:0] src, input logic [9:0] dst, input int len,
                            input int inject_at, input int abort_at);
        int cyc;
        for (int i = 0; i < 256; i++) dst_mem[i] = 32'hdead_beef;
        build_exp(src, dst, len);
        @(posedge ACLK); #1;
        r_src_addr = src; r_dst_addr = dst; r_len = 10'(len); w_start = 1'b1;
        @(posedge ACLK); #1;
        w_start = 1'b0;
        chk("busy_after_start", 64'(bus.rready), 64'd1);
        cyc = 0;
        while (bus.rready && cyc < 5000) begin
            @(negedge ACLK);
            cyc++;
            if (cyc == inject_at) begin
                r_src_addr = 10'h200; w_start = 1'b1;
            end
            if (cyc == inject_at + 1) begin
                r_src_addr = src; w_start = 1'b0;
            end
            if (cyc == abort_at) begin
                #2 ARESETn = 1'b0;
                #1;
                chk("abort_valids_low", 64'({bus.arvalid, bus.awvalid, bus.wvalid}), 64'd0);
                chk("abort_readies_low", 64'({bus.rready, bus.bready}), 64'd0);
                return;
            end
        end
        chk("done_in_time", 64'(cyc < 5000), 64'd1);
        for (int i = 0; i < (len >> 2); i++)
            chk($sformatf("dst_word_%0d", i), 64'(dst_mem[int'(dst[9:2]) + i]), 64'(src_mem[int'(src[9:2]) + i]));
        chk("dst_untouched_after", 64'(dst_mem[int'(dst[9:2]) + (len >> 2)]), 64'h0dead_beef);
        chk("exp_left_over", 64'(exp_ar_addr.size() + exp_aw_addr.size() + exp_wd.size()), 64'd0);
    endtask

    task automatic idle_start(input int len, input string tag);
        valid_seen = 0;
        @(posedge ACLK); #1;
        r_src_addr = 10'h000; r_dst_addr = 10'h100; r_len = 10'(len); w_start = 1'b1;
        @(posedge ACLK); #1;
        w_start = 1'b0;
        repeat (20) @(negedge ACLK);
        chk({tag, "_no_valid"}, 64'(valid_seen), 64'd0);
        chk({tag, "_idle"}, 64'({bus.rready, bus.bready, bus.wvalid}), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) src_mem[i] = 32'(i + 1);
        repeat (3) @(posedge ACLK);
        #2;
        chk("rst_valids", 64'({bus.arvalid, bus.awvalid, bus.wvalid}), 64'd0);
        chk("rst_readies", 64'({bus.rready, bus.bready}), 64'd0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;

        run_copy(10'h000, 10'h000, 160, -1, -1);
        run_copy(10'h008, 10'h108, 24, -1, -1);
        idle_start(0, "len0");
        idle_start(3, "len3");

        stall = 1'b1;
        run_copy(10'h000, 10'h000, 160, -1, -1);
        stall = 1'b0;

        run_copy(10'h000, 10'h000, 160, 15, -1);

        run_copy(10'h000, 10'h000, 160, -1, 20);
        repeat (3) @(posedge ACLK);
        clear_exp();
        #1;
        ARESETn = 1'b1;
        valid_seen = 0;
        repeat (5) @(negedge ACLK);
        chk("post_reset_quiet", 64'(valid_seen), 64'd0);
        run_copy(10'h000, 10'h040, 160, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
